dac_stream_capture: RTL and testbench
=====================================

DAC_STREAM_CAPTURE -- requirements
Module: dac_stream_capture

Interface
REQ-001 Parameter DEPTH, default 64: sample buffer depth in words, power of two.
REQ-002 Parameter IDLE_GAP, default 4: consecutive dac_en-low cycles that end a frame, range 2..15.
REQ-003 clk  in  1  sole clock; all logic is rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 dac_d  in  13  signed DAC data bus from the amplifier-drive output.
REQ-006 dac_en  in  1  DAC clock/enable from the amplifier-drive output.
REQ-007 arm  in  1  single-cycle pulse that arms capture of the next frame.
REQ-008 release  in  1  single-cycle pulse that frees a locked buffer.
REQ-009 rd_en  in  1  buffer read request.
REQ-010 rd_addr  in  log2(DEPTH)  buffer read address.
REQ-011 rd_data  out  13  read data.
REQ-012 rd_valid  out  1  rd_data qualifier.
REQ-013 frame_done  out  1  single-cycle pulse at end of frame.
REQ-014 frame_len  out  log2(DEPTH)+1  number of stored samples in the last frame.
REQ-015 ovf  out  1  sticky flag: the frame exceeded DEPTH samples.
REQ-016 busy  out  1  high in CAPTURE or LOCKED.

Function
REQ-017 dac_en and dac_d shall be registered once on entry; all detection shall use the registered copies.
REQ-018 A sample event shall be a 0->1 transition of registered dac_en; dac_d registered in the same cycle is the sample.
REQ-019 FSM states: IDLE, ARMED, CAPTURE, LOCKED.
REQ-020 IDLE->ARMED on arm; ARMED->CAPTURE on the first sample event; CAPTURE->LOCKED when dac_en has been low for IDLE_GAP consecutive cycles; LOCKED->IDLE on release.
REQ-021 Each sample event in CAPTURE shall first write the pending register to the buffer, then load the new sample into the pending register (one-behind store).
REQ-022 At frame end the pending register shall be discarded; it holds the DAC clear strobe.
REQ-023 Write address shall start at 0 per frame and increment per stored sample; writes beyond DEPTH-1 shall be dropped, ovf set, and frame_len saturated at DEPTH.
REQ-024 frame_done shall pulse for one cycle on the CAPTURE->LOCKED transition; frame_len shall be valid in that cycle and held until the next frame_done.
REQ-025 A frame with a single sample event shall give frame_len = 0.
REQ-026 rd_data shall be returned with one cycle of latency: rd_valid = 1 in the cycle after rd_en.
REQ-027 Reads shall be honoured in IDLE and LOCKED only; rd_en in ARMED or CAPTURE shall give rd_valid = 0.
REQ-028 arm outside IDLE, and release outside LOCKED, shall be ignored.
REQ-029 arm and release in the same cycle in LOCKED: release takes effect; arm is ignored.
REQ-030 ovf shall clear only on arm accepted from IDLE, or on reset.
REQ-031 Sample events in IDLE or LOCKED shall not alter the buffer.

Reset
REQ-032 Asserting rst_n low shall immediately force: state IDLE, rd_data 0, rd_valid 0, frame_done 0, frame_len 0, ovf 0, busy 0, write address 0, gap counter 0, input registers 0.
REQ-033 Buffer contents need not be cleared by reset.
REQ-034 Reset during CAPTURE shall abandon the frame with no frame_done.

Configuration
REQ-035 Macro DAC_CAP_PEAK_EN: when defined, add output peak_abs (13 bits, unsigned).
REQ-036 peak_abs shall hold the maximum |sample| over samples stored in the current frame.
REQ-037 peak_abs shall clear on an accepted arm, with -4096 saturating to 4095.
REQ-038 When DAC_CAP_PEAK_EN is undefined, peak_abs and its logic shall be absent and all other behaviour shall be unchanged.

Verification
REQ-039 Arm, then 5 dac_en pulses carrying 100, -200, 300, 4095, then clear 0, then 4 low cycles -> frame_done once; frame_len = 4; buffer[0..3] = 100, -200, 300, 4095.
REQ-040 Arm, then DEPTH+3 sample events, then gap -> ovf = 1, frame_len = DEPTH, buffer holds the first DEPTH samples.
REQ-041 A dac_en gap of IDLE_GAP-1 cycles mid-frame -> no frame_done; capture continues.
REQ-042 rd_en in CAPTURE -> rd_valid stays 0; rd_en with addr 2 in LOCKED -> next cycle rd_valid = 1 and rd_data = buffer[2].
REQ-043 rst_n low mid-CAPTURE -> outputs at reset values immediately; subsequent sample events are ignored until arm.
REQ-044 With DAC_CAP_PEAK_EN defined, samples 10, -3000, 2000 plus clear -> peak_abs = 3000.

Source files
------------

// File: rtl/dac_stream_capture.sv
// dac_stream_capture: arms on request, captures one DAC frame one-behind into a
// sample buffer, then locks it for readback. Optional peak tracker: DAC_CAP_PEAK_EN.
module dac_stream_capture #(
    parameter int  DEPTH    = 64,
    parameter int  IDLE_GAP = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [12:0] dac_d,
    input  logic               dac_en,
    input  logic               arm,
    input  logic               release_req,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [12:0]        rd_data,
    output logic               rd_valid,
    output logic               frame_done,
    output logic [AW:0]        frame_len,
    output logic               ovf,
`ifdef DAC_CAP_PEAK_EN
    output logic [12:0]        peak_abs,
`endif
    output logic               busy
);

    // state   | meaning
    // IDLE    | buffer free, reads allowed, waiting for arm
    // ARMED   | waiting for the first sample event of a frame
    // CAPTURE | storing samples one behind, watching for the end-of-frame gap
    // LOCKED  | frame complete, buffer held for readback until release
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_LOCKED} state_t;

    localparam logic [AW:0] FULL       = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
    localparam logic [3:0]  GAP_RELOAD = 4'(IDLE_GAP - 1);

    state_t             state;
    logic               en_q;
    logic               en_qq;
    logic signed [12:0] d_q;
    logic signed [12:0] pending;
    logic [3:0]         gap_cnt;
    logic [AW:0]        wr_cnt;
    logic [12:0]        mem [DEPTH];
    logic               sample_ev;
    logic               full;
    logic               store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= 1'b0;
            en_qq <= 1'b0;
            d_q   <= '0;
        end else begin
            en_q  <= dac_en;
            en_qq <= en_q;
            d_q   <= dac_d;
        end
    end

    assign sample_ev = en_q & ~en_qq;
    assign full      = (wr_cnt == FULL);
    assign store     = (state == S_CAPTURE) && sample_ev && !full;

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_cnt[AW-1:0]] <= pending;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pending    <= '0;
            gap_cnt    <= '0;
            wr_cnt     <= '0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rd_valid   <= 1'b0;
            if (rd_en && (state == S_IDLE || state == S_LOCKED)) begin
                rd_data  <= mem[rd_addr];
                rd_valid <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (arm) begin
                        state  <= S_ARMED;
                        ovf    <= 1'b0;
                        wr_cnt <= '0;
                    end
                end

                S_ARMED: begin
                    if (sample_ev) begin
                        state   <= S_CAPTURE;
                        busy    <= 1'b1;
                        pending <= d_q;
                        wr_cnt  <= '0;
                        gap_cnt <= GAP_RELOAD;
                    end
                end

                S_CAPTURE: begin
                    // The previous sample is committed only once a newer one arrives,
                    // so the trailing clear strobe left in pending never reaches memory.
                    if (sample_ev) begin
                        pending <= d_q;
                        if (full) begin
                            ovf <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + CNT_ONE;
                        end
                    end

                    if (en_q) begin
                        gap_cnt <= GAP_RELOAD;
                    end else if (gap_cnt == 4'd0) begin
                        state      <= S_LOCKED;
                        frame_done <= 1'b1;
                        frame_len  <= wr_cnt;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                S_LOCKED: begin
                    if (release_req) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DAC_CAP_PEAK_EN
    logic [12:0] pend_abs;

    // -4096 has no positive 13-bit counterpart, so it saturates to 4095.
    always_comb begin
        pend_abs = pending;
        if (pending[12]) begin
            if (pending[11:0] == 12'd0) begin
                pend_abs = 13'd4095;
            end else begin
                pend_abs = ~pending + 13'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_abs <= '0;
        end else if (state == S_IDLE && arm) begin
            peak_abs <= '0;
        end else if (store && (pend_abs > peak_abs)) begin
            peak_abs <= pend_abs;
        end
    end
`endif

endmodule

// File: tb/tb_dac_stream_capture.sv
// Randomized self-checking bench for dac_stream_capture against a frame-level
// reference model (stored = all but the last sample, capped at DEPTH).
module tb_dac_stream_capture;

    localparam int DEPTH    = 64;
    localparam int IDLE_GAP = 4;
    localparam int AW       = $clog2(DEPTH);

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [12:0] dac_d;
    logic               dac_en;
    logic               arm;
    logic               release_req;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [12:0]        rd_data;
    logic               rd_valid;
    logic               frame_done;
    logic [AW:0]        frame_len;
    logic               ovf;
    logic               busy;
`ifdef DAC_CAP_PEAK_EN
    logic [12:0]        peak_abs;
`endif

    int checks = 0;
    int errors = 0;
    int fd_count = 0;
    logic [AW:0] fd_len;

    logic signed [12:0] stim_q [$];
    logic signed [12:0] exp_buf [DEPTH];
    int exp_len;
    int exp_ovf;
    int exp_peak;

    always #5 clk = ~clk;

    dac_stream_capture #(.DEPTH(DEPTH), .IDLE_GAP(IDLE_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .dac_d(dac_d), .dac_en(dac_en), .arm(arm),
        .release_req(release_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .frame_done(frame_done),
        .frame_len(frame_len), .ovf(ovf),
`ifdef DAC_CAP_PEAK_EN
        .peak_abs(peak_abs),
`endif
        .busy(busy)
    );

    always @(posedge clk) begin
        #2;
        if (frame_done === 1'b1) begin
            fd_count++;
            fd_len = frame_len;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_pulse(input logic signed [12:0] v, input int lows);
        dac_d  = v;
        dac_en = 1'b1;
        tick();
        dac_en = 1'b0;
        repeat (lows) tick();
    endtask

    task automatic run_frame(input int gap_max);
        int g;
        for (int i = 0; i < stim_q.size(); i++) begin
            g = (i == stim_q.size() - 1) ? IDLE_GAP : int'($urandom_range(1, gap_max));
            send_pulse(stim_q[i], g);
        end
        repeat (3) tick();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_release();
        release_req = 1'b1;
        tick();
        release_req = 1'b0;
    endtask

    task automatic do_read(input int addr, output logic [12:0] data, output logic valid);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        tick();
        data  = rd_data;
        valid = rd_valid;
        rd_en = 1'b0;
    endtask

    // Frame model: every sample but the last is stored, first DEPTH kept.
    task automatic build_expect();
        int n, a;
        n        = stim_q.size() - 1;
        exp_len  = (n > DEPTH) ? DEPTH : n;
        exp_ovf  = (n > DEPTH) ? 1 : 0;
        exp_peak = 0;
        for (int i = 0; i < exp_len; i++) begin
            exp_buf[i] = stim_q[i];
            a = int'(stim_q[i]);
            if (a < 0) a = -a;
            if (a > 4095) a = 4095;
            if (a > exp_peak) exp_peak = a;
        end
    endtask

    task automatic random_stim(input int n);
        stim_q = {};
        for (int i = 0; i < n; i++) stim_q.push_back(13'($urandom_range(0, 8191)));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dac_d = '0; dac_en = 1'b0; arm = 1'b0;
        release_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (frame_len !== '0) begin errors++; $display("FAIL reset_frame_len: got %0d expected 0", frame_len); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int f0; logic [12:0] d; logic v;
        do_arm();
        stim_q = {};
        stim_q.push_back(13'sd100); stim_q.push_back(-13'sd200); stim_q.push_back(13'sd300);
        stim_q.push_back(13'sd4095); stim_q.push_back(13'sd0);
        build_expect();
        f0 = fd_count;
        run_frame(1);
        checks++; if (fd_count - f0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", fd_count - f0); end
        checks++; if (fd_len !== 7'd4) begin errors++; $display("FAIL basic_len_at_done: got %0d expected 4", fd_len); end
        checks++; if (frame_len !== (AW+1)'(exp_len)) begin errors++; $display("FAIL basic_len_held: got %0d expected %0d", frame_len, exp_len); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_locked: got %b expected 1", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
        for (int i = 0; i < 4; i++) begin
            do_read(i, d, v);
            checks++; if (v !== 1'b1 || d !== exp_buf[i]) begin errors++; $display("FAIL basic_buf[%0d]: got valid=%b data=%0d expected valid=1 data=%0d", i, v, $signed(d), exp_buf[i]); end
        end
        do_release();
        tick();
    endtask

    task automatic test_gap();
        int f0; logic [12:0] d; logic v;
        do_arm();
        f0 = fd_count;
        send_pulse(13'sd7, 1);
        do_release();
        send_pulse(-13'sd1234, IDLE_GAP - 1);
        checks++; if (fd_count - f0 !== 0) begin errors++; $display("FAIL gap_no_done: got %0d frame_done expected 0", fd_count - f0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_still_capturing: got busy=%b expected 1", busy); end
        send_pulse(13'sd55, 1);
        send_pulse(13'sd0, IDLE_GAP);
        repeat (3) tick();
        checks++; if (fd_count - f0 !== 1) begin errors++; $display("FAIL gap_done_count: got %0d expected 1", fd_count - f0); end
        checks++; if (frame_len !== 7'd3) begin errors++; $display("FAIL gap_len: got %0d expected 3", frame_len); end
        do_read(1, d, v);
        checks++; if (v !== 1'b1 || d !== 13'h1B2E) begin errors++; $display("FAIL gap_buf1: got valid=%b data=%0d expected valid=1 data=-1234", v, $signed(d)); end
        do_release();
        tick();
    endtask

    task automatic test_read_capture();
        logic [12:0] d; logic v;
        do_arm();
        do_read(0, d, v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL read_armed_valid: got %b expected 0", v); end
        send_pulse(13'sd11, 1);
        send_pulse(13'sd22, 1);
        do_read(0, d, v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL read_capture_valid: got %b expected 0", v); end
        send_pulse(13'sd33, 1);
        send_pulse(13'sd44, 1);
        send_pulse(13'sd55, IDLE_GAP);
        repeat (3) tick();
        do_read(2, d, v);
        checks++; if (v !== 1'b1 || d !== 13'd33) begin errors++; $display("FAIL read_locked_addr2: got valid=%b data=%0d expected valid=1 data=33", v, $signed(d)); end
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL read_valid_one_cycle: got %b expected 0", rd_valid); end
    endtask

    task automatic test_arm_release();
        int f0; logic [12:0] d; logic v;
        f0 = fd_count;
        do_arm();
        for (int i = 0; i < 3; i++) send_pulse(13'sd999, 1);
        repeat (IDLE_GAP + 3) tick();
        checks++; if (fd_count - f0 !== 0 || busy !== 1'b1) begin errors++; $display("FAIL locked_arm_ignored: got done=%0d busy=%b expected done=0 busy=1", fd_count - f0, busy); end
        do_read(0, d, v);
        checks++; if (d !== 13'd11) begin errors++; $display("FAIL locked_buffer_kept: got %0d expected 11", $signed(d)); end
        arm = 1'b1; release_req = 1'b1;
        tick();
        arm = 1'b0; release_req = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arm_release_busy: got %b expected 0", busy); end
        for (int i = 0; i < 3; i++) send_pulse(13'sd777, 1);
        repeat (IDLE_GAP + 3) tick();
        checks++; if (fd_count - f0 !== 0 || busy !== 1'b0) begin errors++; $display("FAIL arm_release_not_armed: got done=%0d busy=%b expected done=0 busy=0", fd_count - f0, busy); end
        do_read(1, d, v);
        checks++; if (v !== 1'b1 || d !== 13'd22) begin errors++; $display("FAIL idle_read_addr1: got valid=%b data=%0d expected valid=1 data=22", v, $signed(d)); end
    endtask

    task automatic test_overflow();
        int f0; int bad; logic [12:0] d; logic v;
        do_arm();
        random_stim(DEPTH + 3);
        build_expect();
        f0 = fd_count;
        run_frame(1);
        checks++; if (fd_count - f0 !== 1) begin errors++; $display("FAIL ovf_done_count: got %0d expected 1", fd_count - f0); end
        checks++; if (ovf !== 1'(exp_ovf)) begin errors++; $display("FAIL ovf_flag: got %b expected %0d", ovf, exp_ovf); end
        checks++; if (frame_len !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL ovf_len: got %0d expected %0d", frame_len, DEPTH); end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            do_read(i, d, v);
            if (v !== 1'b1 || d !== exp_buf[i]) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_buffer: got %0d bad words expected 0", bad); end
        do_release();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
        do_arm();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_arm: got %b expected 0", ovf); end
    endtask

    task automatic test_random_frames();
        int f0; int n; int bad; int a; logic [12:0] d; logic v;
        for (int it = 0; it < 8; it++) begin
            n = (it == 0) ? 1 : int'($urandom_range(2, 20));
            do_arm();
            random_stim(n);
            build_expect();
            f0 = fd_count;
            run_frame(IDLE_GAP - 1);
            checks++; if (fd_count - f0 !== 1) begin errors++; $display("FAIL rand%0d_done_count: got %0d expected 1", it, fd_count - f0); end
            checks++; if (frame_len !== (AW+1)'(exp_len) || ovf !== 1'(exp_ovf)) begin errors++; $display("FAIL rand%0d_len_ovf: got len=%0d ovf=%b expected len=%0d ovf=%0d", it, frame_len, ovf, exp_len, exp_ovf); end
`ifdef DAC_CAP_PEAK_EN
            checks++; if (peak_abs !== 13'(exp_peak)) begin errors++; $display("FAIL rand%0d_peak: got %0d expected %0d", it, peak_abs, exp_peak); end
`endif
            bad = 0;
            for (int i = 0; i < exp_len; i++) begin
                do_read(i, d, v);
                if (v !== 1'b1 || d !== exp_buf[i]) bad++;
            end
            checks++; if (bad !== 0) begin errors++; $display("FAIL rand%0d_buffer: got %0d bad words expected 0", it, bad); end
            do_release();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_release: got busy=%b expected 0", it, busy); end
            for (int i = 0; i < 3; i++) send_pulse(13'($urandom_range(0, 8191)), 1);
            repeat (IDLE_GAP + 3) tick();
            if (exp_len > 0) begin
                a = int'($urandom_range(0, exp_len - 1));
                do_read(a, d, v);
                checks++; if (v !== 1'b1 || d !== exp_buf[a]) begin errors++; $display("FAIL rand%0d_idle_events: got buf[%0d]=%0d expected %0d", it, a, $signed(d), exp_buf[a]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        do_arm();
        f0 = fd_count;
        for (int i = 0; i < 3; i++) send_pulse(13'sd321, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || ovf !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got busy=%b ovf=%b done=%b expected 0 0 0", busy, ovf, frame_done); end
        checks++; if (frame_len !== '0 || rd_valid !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL rstmid_outputs: got len=%0d valid=%b data=%0d expected 0 0 0", frame_len, rd_valid, rd_data); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) send_pulse(13'sd123, 1);
        repeat (IDLE_GAP + 3) tick();
        checks++; if (fd_count - f0 !== 0 || busy !== 1'b0 || frame_len !== '0) begin errors++; $display("FAIL rstmid_ignored: got done=%0d busy=%b len=%0d expected 0 0 0", fd_count - f0, busy, frame_len); end
    endtask

`ifdef DAC_CAP_PEAK_EN
    task automatic test_peak();
        do_arm();
        checks++; if (peak_abs !== '0) begin errors++; $display("FAIL peak_clear_on_arm: got %0d expected 0", peak_abs); end
        stim_q = {};
        stim_q.push_back(13'sd10); stim_q.push_back(-13'sd3000);
        stim_q.push_back(13'sd2000); stim_q.push_back(13'sd0);
        run_frame(1);
        checks++; if (peak_abs !== 13'd3000) begin errors++; $display("FAIL peak_3000: got %0d expected 3000", peak_abs); end
        do_release();
        do_arm();
        stim_q = {};
        stim_q.push_back(13'h1000); stim_q.push_back(13'sd5); stim_q.push_back(13'sd0);
        run_frame(1);
        checks++; if (peak_abs !== 13'd4095) begin errors++; $display("FAIL peak_saturate: got %0d expected 4095", peak_abs); end
        do_release();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_read_capture();
        test_arm_release();
        test_overflow();
        test_random_frames();
        test_reset_mid();
`ifdef DAC_CAP_PEAK_EN
        test_peak();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
